// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches one byte at PC over a req/ack memory port and strobes it into the IR.
// Optional build macro FETCH_TIMEOUT_EN adds a mem_ack watchdog that raises fetch_err.
`default_nettype none

module instruction_fetch_unit #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir_in,
  output logic              ir_load,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t state;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= '0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
      ir_in    <= '0;
      ir_load  <= 1'b0;
      busy     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      ir_load <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // The jump lands first so a simultaneous fetch reads the jump target.
          if (jump_en) begin
            pc       <= jump_addr;
            mem_addr <= jump_addr;
          end
          if (fetch_start) begin
            state   <= REQ;
            mem_req <= 1'b1;
            busy    <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        REQ: begin
          if (mem_ack) begin
            ir_in   <= mem_rdata;
            mem_req <= 1'b0;
            ir_load <= 1'b1;
            state   <= LOAD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == LAST_WAIT) begin
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        LOAD: begin
          pc       <= pc + 1'b1;
          mem_addr <= pc + 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: vector table, reset/timeout sequences and randomized fetches vs. a PC/memory model.
`default_nettype none

module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_start;
  logic       jump_en;
  logic [3:0] jump_addr;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] ir_in;
  logic       ir_load;
  logic [3:0] pc;
  logic       busy;
  logic       fetch_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [16];
  logic [3:0] pc_m;

  typedef struct {
    logic       jump;
    logic [3:0] jaddr;
    int         waits;
    logic       poke;
    logic [3:0] exp_addr;
    logic [7:0] exp_ir;
    logic [3:0] exp_pc;
  } vec_t;

  vec_t vecs [4];

  instruction_fetch_unit #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .ir_in       (ir_in),
    .ir_load     (ir_load),
    .pc          (pc),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One complete fetch: start, optional wait states (with ignored pokes), ack, LOAD, back to IDLE.
  task automatic do_fetch(input logic jump, input logic [3:0] jaddr, input int waits,
                          input logic poke, input logic [3:0] exp_addr,
                          input logic [7:0] exp_ir, input logic [3:0] exp_pc);
    jump_en     = jump;
    jump_addr   = jaddr;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    jump_en     = 1'b0;
    chk("req_asserted", mem_req, 1'b1);
    chk("req_busy", busy, 1'b1);
    chk("req_addr", mem_addr, exp_addr);
    chk("req_no_load", ir_load, 1'b0);
    for (int w = 0; w < waits; w++) begin
      if (poke) begin
        fetch_start = 1'b1;
        jump_en     = 1'b1;
        jump_addr   = ~exp_addr;
      end
      mem_ack = 1'b0;
      tick();
      chk("wait_req_held", mem_req, 1'b1);
      chk("wait_addr_stable", mem_addr, exp_addr);
      chk("wait_no_load", ir_load, 1'b0);
    end
    mem_ack   = 1'b1;
    mem_rdata = mem[mem_addr];
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    chk("load_strobe", ir_load, 1'b1);
    chk("load_ir", ir_in, exp_ir);
    chk("load_req_dropped", mem_req, 1'b0);
    chk("load_busy", busy, 1'b1);
    if (poke) begin
      fetch_start = 1'b1;
      jump_en     = 1'b1;
      jump_addr   = ~exp_addr;
    end
    tick();
    fetch_start = 1'b0;
    jump_en     = 1'b0;
    chk("done_strobe_off", ir_load, 1'b0);
    chk("done_pc", pc, exp_pc);
    chk("done_addr_mirror", mem_addr, exp_pc);
    chk("done_idle", busy, 1'b0);
    chk("done_ir_held", ir_in, exp_ir);
    // A stray ack in IDLE must not load anything.
    mem_ack   = 1'b1;
    mem_rdata = ~exp_ir;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_ignored_ir", ir_in, exp_ir);
    chk("idle_ack_no_load", ir_load, 1'b0);
    chk("idle_ack_no_req", mem_req, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[4'h0] = 8'hAF;
    mem[4'h1] = 8'h3C;
    mem[4'hE] = 8'h05;
    mem[4'hF] = 8'h9D;

    vecs[0] = '{jump: 1'b0, jaddr: 4'h0, waits: 0, poke: 1'b0, exp_addr: 4'h0, exp_ir: 8'hAF, exp_pc: 4'h1};
    vecs[1] = '{jump: 1'b0, jaddr: 4'h0, waits: 3, poke: 1'b0, exp_addr: 4'h1, exp_ir: 8'h3C, exp_pc: 4'h2};
    vecs[2] = '{jump: 1'b1, jaddr: 4'hE, waits: 1, poke: 1'b0, exp_addr: 4'hE, exp_ir: 8'h05, exp_pc: 4'hF};
    vecs[3] = '{jump: 1'b0, jaddr: 4'h0, waits: 2, poke: 1'b1, exp_addr: 4'hF, exp_ir: 8'h9D, exp_pc: 4'h0};

    rst         = 1'b0;
    fetch_start = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 4'h0;
    mem_ack     = 1'b0;
    mem_rdata   = 8'h00;
    tick();
    tick();
    chk("rst_state_req", mem_req, 1'b0);
    chk("rst_state_pc", pc, 4'h0);
    chk("rst_state_addr", mem_addr, 4'h0);
    chk("rst_state_ir", ir_in, 8'h00);
    chk("rst_state_load", ir_load, 1'b0);
    chk("rst_state_busy", busy, 1'b0);
    chk("rst_state_err", fetch_err, 1'b0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++)
      do_fetch(vecs[i].jump, vecs[i].jaddr, vecs[i].waits, vecs[i].poke,
               vecs[i].exp_addr, vecs[i].exp_ir, vecs[i].exp_pc);

    // Asynchronous reset in the middle of a request.
    jump_en     = 1'b1;
    jump_addr   = 4'h5;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    jump_en     = 1'b0;
    chk("midreq_req", mem_req, 1'b1);
    chk("midreq_pc", pc, 4'h5);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 1'b0);
    chk("async_rst_pc", pc, 4'h0);
    chk("async_rst_busy", busy, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_hold_no_load", ir_load, 1'b0);
      chk("rst_hold_ir", ir_in, 8'h00);
    end
    mem_ack = 1'b0;
    rst     = 1'b1;
    tick();
    pc_m = 4'h0;

    for (int n = 0; n < 40; n++) begin
      logic       j;
      logic [3:0] ja;
      logic [3:0] a;
      j    = ($urandom_range(0, 2) == 0);
      ja   = 4'($urandom);
      a    = j ? ja : pc_m;
      do_fetch(j, ja, $urandom_range(0, 4), 1'($urandom), a, mem[a], 4'((a + 1) % 16));
      pc_m = 4'((a + 1) % 16);
    end

`ifdef FETCH_TIMEOUT_EN
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_no_err_yet", fetch_err, 1'b0);
      chk("to_req_held", mem_req, 1'b1);
    end
    tick();
    chk("to_err_pulse", fetch_err, 1'b1);
    chk("to_req_dropped", mem_req, 1'b0);
    chk("to_idle", busy, 1'b0);
    chk("to_pc_kept", pc, pc_m);
    chk("to_no_load", ir_load, 1'b0);
    tick();
    chk("to_err_single", fetch_err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
